// File: rtl/peq_pkg.sv
// Shared types for the priority-encoder event queue.
//   peq_state_t : stability filter states
//   peq_code_t  : 3-bit encoder code (active-low Q or decoded event code)
package peq_pkg;

  localparam int unsigned ENC_W = 3;

  typedef logic [ENC_W-1:0] peq_code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } peq_state_t;

  // Encoder Q is active-low; the event code is its complement.
  function automatic peq_code_t q_to_code(input peq_code_t q);
    return ~q;
  endfunction

endpackage

// File: rtl/peq_fifo.sv
// First-word-fall-through FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   push_i, data_i : write request and data (accepted when not full, or full with pop)
//   pop_i          : remove head (ignored when empty)
//   data_o         : head entry, zero when empty
//   full_o/empty_o : occupancy flags
module peq_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/prio_event_queue.sv
// Event queue behind a 74LS148-style priority encoder.
// Synchronises {gs,q,eo}, filters the code for stability, pushes one event
// per accepted request into a FWFT FIFO drained by a valid/ready consumer.
// Optional feature macro: PEQ_TIMESTAMP_EN (adds TS_W timestamp per entry and evt_ts port).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   enc_q/enc_gs/enc_eo : raw encoder outputs (active low, asynchronous)
//   evt_ready           : consumer takes head event
//   evt_valid/evt_code  : FIFO non-empty / head code (0 when empty)
//   enc_idle            : synchronised ~eo
//   ovf, ovf_clr        : sticky drop flag and its clear
//   evt_ts              : head timestamp (PEQ_TIMESTAMP_EN only)
module prio_event_queue
  import peq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DEPTH         = 4
`ifdef PEQ_TIMESTAMP_EN
  ,parameter int unsigned TS_W         = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ENC_W-1:0] enc_q,
  input  logic             enc_gs,
  input  logic             enc_eo,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [ENC_W-1:0] evt_code,
  output logic             enc_idle,
  output logic             ovf,
  input  logic             ovf_clr
`ifdef PEQ_TIMESTAMP_EN
  ,output logic [TS_W-1:0] evt_ts
`endif
);

  localparam int unsigned SYNC_W = ENC_W + 2;
  localparam int unsigned CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PEQ_TIMESTAMP_EN
  localparam int unsigned FIFO_W = ENC_W + TS_W;
`else
  localparam int unsigned FIFO_W = ENC_W;
`endif

  // 2-FF synchroniser; reset to all-ones so the encoder looks inactive.
  logic [SYNC_W-1:0] sync1_q, sync2_q;
  logic              gs_s, eo_s;
  peq_code_t         q_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {enc_gs, enc_q, enc_eo};
      sync2_q <= sync1_q;
    end
  end

  assign gs_s     = sync2_q[SYNC_W-1];
  assign q_s      = sync2_q[ENC_W:1];
  assign eo_s     = sync2_q[0];
  assign enc_idle = ~eo_s;

  // Stability filter: state register.
  peq_state_t       state_q, state_d;
  peq_code_t        cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stability filter: next state. Any code change restarts the count.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!gs_s) begin
          state_d = SETTLE;
          cand_d  = q_s;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (gs_s) begin
          state_d = IDLE;
        end else if (q_s != cand_q) begin
          cand_d = q_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (gs_s) begin
          state_d = IDLE;
        end else if (q_s != cand_q) begin
          state_d = SETTLE;
          cand_d  = q_s;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stability filter: output decode (one push on the SETTLE->HELD step).
  always_comb begin
    push_c = 1'b0;
    if (state_q == SETTLE && !gs_s && q_s == cand_q && cnt_q == CNT_LAST) push_c = 1'b1;
  end

  // Registered push request and code into the FIFO.
  logic      push_q;
  peq_code_t push_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q      <= 1'b0;
      push_code_q <= '0;
    end else begin
      push_q      <= push_c;
      push_code_q <= q_to_code(cand_q);
    end
  end

  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty, pop;

`ifdef PEQ_TIMESTAMP_EN
  // Free-running timestamp, sampled on the cycle the entry is written.
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  assign fifo_wdata = {ts_q, push_code_q};
  assign evt_ts     = fifo_rdata[FIFO_W-1:ENC_W];
`else
  assign fifo_wdata = push_code_q;
`endif

  assign pop       = evt_ready && !fifo_empty;
  assign evt_valid = !fifo_empty;
  assign evt_code  = fifo_rdata[ENC_W-1:0];

  peq_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push_q && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_prio_event_queue.sv
// Bench for prio_event_queue (STABLE_CYCLES=4, DEPTH=4). Reference model:
// an event is produced when a (gs=0, q) value has been presented for
// STABLE_CYCLES+1 consecutive cycles, and enters a DEPTH-entry queue
// STABLE_CYCLES+3 edges after it first appeared.
module tb_prio_event_queue;

  localparam int S = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] enc_q;
  logic       enc_gs, enc_eo, evt_ready, ovf_clr;
  logic       evt_valid, enc_idle, ovf;
  logic [2:0] evt_code;
`ifdef PEQ_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  prio_event_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enc_q     (enc_q),
    .enc_gs    (enc_gs),
    .enc_eo    (enc_eo),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .enc_idle  (enc_idle),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef PEQ_TIMESTAMP_EN
    ,.evt_ts   (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_q[$];
  int pend[$];
  bit m_ovf;
  int run;
  int prev_key;
  logic eo_v = 1'b1;

  function automatic int m_head();
    return (m_q.size() > 0) ? m_q[0] : 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    pend = '{-1, -1, -1};
    m_ovf = 1'b0;
    run = 0;
    prev_key = 8;
  endtask

  // One clock: drive inputs at negedge, advance model for the coming edge, settle after it.
  task automatic cycle(input logic gs, input logic [2:0] q, input logic rdy, input logic clr);
    int key;
    int p;
    bit popd;
    logic [2:0] nq;
    @(negedge clk);
    enc_gs = gs; enc_q = q; evt_ready = rdy; ovf_clr = clr; enc_eo = eo_v;
    nq  = ~q;
    key = gs ? 8 : int'(q);
    if (key == prev_key) run++;
    else run = 1;
    prev_key = key;
    pend.push_back((!gs && run == S + 1) ? int'(nq) : -1);
    p = pend.pop_front();
    popd = (m_q.size() > 0) && rdy;
    if (clr) m_ovf = 1'b0;
    if (p >= 0) begin
      if (m_q.size() == D && !popd) m_ovf = 1'b1;
      else m_q.push_back(p);
    end
    if (popd) void'(m_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic hold(input logic gs, input logic [2:0] q, input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(gs, q, rdy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enc_gs = 1'b0; enc_q = 3'b000; enc_eo = 1'b1;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    total++; if (evt_code !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", evt_code); end
    total++; if (enc_idle !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", enc_idle); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    release_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 3'b000, 1'b0, 1'b0);
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL latency_early edge=%0d got=%b exp=0", i, evt_valid); end
    end
    cycle(1'b0, 3'b000, 1'b0, 1'b0);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL latency_edge7 got=%b exp=1", evt_valid); end
    total++; if (evt_code !== 3'd7) begin bad++; $display("FAIL first_code got=%0d exp=7", evt_code); end
    eo_v = 1'b0;
    hold(1'b1, 3'b111, 1'b0, 2);
    total++; if (enc_idle !== 1'b1) begin bad++; $display("FAIL enc_idle got=%b exp=1", enc_idle); end
    eo_v = 1'b1;
    cycle(1'b1, 3'b111, 1'b1, 1'b0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL pop_empty got=%b exp=0", evt_valid); end
    cycle(1'b1, 3'b111, 1'b1, 1'b0);
    total++; if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin bad++; $display("FAIL ready_on_empty valid=%b code=%0d exp 0/0", evt_valid, evt_code); end
  endtask

  task automatic test_glitch();
    hold(1'b0, ~3'd2, 1'b0, 3);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 3'b111, 1'b0, 1'b0);
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL glitch cyc=%0d got=%b exp=0", i, evt_valid); end
    end
  endtask

  task automatic test_upgrade();
    hold(1'b0, ~3'd2, 1'b0, 10);
    hold(1'b0, ~3'd5, 1'b0, 100);
    hold(1'b1, 3'b111, 1'b0, 3);
    total++; if (evt_code !== 3'd2 || evt_valid !== 1'b1) begin bad++; $display("FAIL upgrade_first code=%0d valid=%b exp 2/1", evt_code, evt_valid); end
    cycle(1'b1, 3'b111, 1'b1, 1'b0);
    total++; if (evt_code !== 3'd5 || evt_valid !== 1'b1) begin bad++; $display("FAIL upgrade_second code=%0d valid=%b exp 5/1", evt_code, evt_valid); end
    cycle(1'b1, 3'b111, 1'b1, 1'b0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL upgrade_count valid=%b exp=0", evt_valid); end
  endtask

  task automatic test_overflow();
    int codes[5] = '{1, 2, 3, 4, 6};
    int exp_c[4] = '{1, 2, 3, 4};
    for (int k = 0; k < 5; k++) hold(1'b0, ~3'(codes[k]), 1'b0, 10);
    hold(1'b1, 3'b111, 1'b0, 3);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    cycle(1'b1, 3'b111, 1'b0, 1'b1);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
    for (int k = 0; k < 4; k++) begin
      total++; if (evt_code !== 3'(exp_c[k]) || evt_valid !== 1'b1) begin bad++; $display("FAIL ovf_order idx=%0d code=%0d exp=%0d", k, evt_code, exp_c[k]); end
      cycle(1'b1, 3'b111, 1'b1, 1'b0);
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained valid=%b exp=0", evt_valid); end
  endtask

  task automatic test_full_pop();
    int exp_c[4] = '{2, 3, 4, 6};
    for (int k = 1; k <= 4; k++) hold(1'b0, ~3'(k), 1'b0, 10);
    hold(1'b0, ~3'd6, 1'b0, 7);
    cycle(1'b0, ~3'd6, 1'b1, 1'b0);
    hold(1'b0, ~3'd6, 1'b0, 5);
    hold(1'b1, 3'b111, 1'b0, 3);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_pop_ovf got=%b exp=0", ovf); end
    for (int k = 0; k < 4; k++) begin
      total++; if (evt_code !== 3'(exp_c[k]) || evt_valid !== 1'b1) begin bad++; $display("FAIL full_pop_order idx=%0d code=%0d exp=%0d", k, evt_code, exp_c[k]); end
      cycle(1'b1, 3'b111, 1'b1, 1'b0);
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL full_pop_drained valid=%b exp=0", evt_valid); end
  endtask

  task automatic test_midreset();
    hold(1'b0, ~3'd3, 1'b0, 10);
    hold(1'b0, ~3'd5, 1'b0, 10);
    hold(1'b1, 3'b111, 1'b0, 2);
    total++; if (evt_valid !== 1'b1 || evt_code !== 3'd3) begin bad++; $display("FAIL midreset_pre valid=%b code=%0d exp 1/3", evt_valid, evt_code); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin bad++; $display("FAIL midreset_async valid=%b code=%0d exp 0/0", evt_valid, evt_code); end
    release_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 3'b111, 1'b1, 1'b0);
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL midreset_post cyc=%0d got=%b exp=0", i, evt_valid); end
    end
  endtask

  task automatic test_random();
    logic gs, rdy, clr;
    logic [2:0] q;
    int len;
    for (int s = 0; s < 120; s++) begin
      gs  = ($urandom % 4 == 0);
      q   = 3'($urandom);
      len = 1 + int'($urandom % 12);
      for (int c = 0; c < len; c++) begin
        rdy = ($urandom % 3 == 0);
        clr = ($urandom % 20 == 0);
        cycle(gs, q, rdy, clr);
        total++; if (evt_valid !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid seg=%0d got=%b exp=%b", s, evt_valid, m_q.size() > 0); end
        total++; if (evt_code !== 3'(m_head())) begin bad++; $display("FAIL rnd_code seg=%0d got=%0d exp=%0d", s, evt_code, m_head()); end
        total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf seg=%0d got=%b exp=%b", s, ovf, m_ovf); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_upgrade();
    test_overflow();
    test_full_pop();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
